// File: rtl/konwersja_pkg.sv
// Shared types and constants for the U2 -> ZM converter.
package konwersja_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int KONW_BITS     = 32;
  localparam int KONW_MAX_BITS = 64;

  // Most negative U2 value of the given width (only bit bits-1 set); widths up to KONW_MAX_BITS.
  function automatic logic [KONW_MAX_BITS-1:0] most_negative(input int bits);
    logic [KONW_MAX_BITS-1:0] v;
    v            = '0;
    v[bits-1]    = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/konwersja_u2_zm.sv
// Two's complement to sign-magnitude converter, negatives negated bit-serially LSB first.
// Define KONW_U2ZM_FAST_EN to convert negatives in a single cycle with a parallel adder.
module konwersja_u2_zm
  import konwersja_pkg::*;
#(
  parameter int BITS = KONW_BITS
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [BITS-1:0] i_arg_A,
  output logic            o_busy,
  output logic            o_done,
  output logic [BITS-1:0] o_result,
  output logic            o_error
);

  localparam int CW = (BITS > 2) ? $clog2(BITS) : 1;
  localparam logic [BITS-1:0] MIN_NEG = BITS'(most_negative(BITS));

  state_t          state_q, state_d;
  logic [BITS-2:0] shreg_q, shreg_d;
  logic            seen_q, seen_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] res_q, res_d;
  logic            err_q, err_d;

`ifdef KONW_U2ZM_FAST_EN
  logic [BITS-2:0] mag_fast;
  assign mag_fast = (~i_arg_A[BITS-2:0]) + (BITS-1)'(1);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      seen_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    logic          out_bit;
    logic [BITS-1:0] shifted;
    state_d = state_q;
    shreg_d = shreg_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    // Copy bits up to and including the first 1, invert everything after it.
    out_bit = seen_q ^ shreg_q[0];
    shifted = {out_bit, shreg_q};
    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (!i_arg_A[BITS-1]) begin
            res_d   = i_arg_A;
            err_d   = 1'b0;
            state_d = DONE;
          end else if (i_arg_A == MIN_NEG) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
`ifdef KONW_U2ZM_FAST_EN
            res_d   = {1'b1, mag_fast};
            err_d   = 1'b0;
            state_d = DONE;
`else
            shreg_d = i_arg_A[BITS-2:0];
            cnt_d   = '0;
            seen_d  = 1'b0;
            state_d = BUSY;
`endif
          end
        end
      end
      BUSY: begin
        // Result bits enter at the top, so after BITS-1 shifts the register holds the magnitude.
        shreg_d = shifted[BITS-1:1];
        seen_d  = seen_q | shreg_q[0];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(BITS-2)) begin
          res_d   = {1'b1, shreg_d};
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_busy   = (state_q != IDLE);
  assign o_done   = (state_q == DONE);
  assign o_result = res_q;
  assign o_error  = err_q;

endmodule

// File: tb/tb_konwersja_u2_zm.sv
// Directed bench for konwersja_u2_zm (BITS=8 and BITS=32 instances) with a result scoreboard.
module tb_konwersja_u2_zm;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst8_n, rst32_n;
  logic        start8, start32;
  logic [7:0]  a8;
  logic [31:0] a32;
  logic        busy8, done8, err8;
  logic [7:0]  res8;
  logic        busy32, done32, err32;
  logic [31:0] res32;

  exp_t sb8[$];
  exp_t sb32[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  konwersja_u2_zm #(.BITS(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst8_n), .i_start(start8), .i_arg_A(a8),
    .o_busy(busy8), .o_done(done8), .o_result(res8), .o_error(err8)
  );

  konwersja_u2_zm #(.BITS(32)) dut32 (
    .i_clk(clk), .i_rst_n(rst32_n), .i_start(start32), .i_arg_A(a32),
    .o_busy(busy32), .o_done(done32), .o_result(res32), .o_error(err32)
  );

  function automatic exp_t model(input int w, input logic [31:0] a);
    exp_t        e;
    logic [31:0] mask, minv, v;
    mask  = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    minv  = 32'd1 << (w - 1);
    v     = a & mask;
    e.lat = 1;
    e.err = 1'b0;
    if ((v & minv) == 32'd0) begin
      e.res = v;
    end else if (v == minv) begin
      e.res = 32'd0;
      e.err = 1'b1;
    end else begin
      e.res = minv | ((32'd0 - v) & mask);
`ifdef KONW_U2ZM_FAST_EN
      e.lat = 1;
`else
      e.lat = w;
`endif
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input bit w32, input logic [31:0] a, input bit push);
    @(negedge clk);
    if (w32) begin
      start32 = 1'b1;
      a32     = a;
      if (push) sb32.push_back(model(32, a));
    end else begin
      start8 = 1'b1;
      a8     = a[7:0];
      if (push) sb8.push_back(model(8, a));
    end
    $display("start w=%0d A=%0h", w32 ? 32 : 8, a);
  endtask

  // Waits for o_done; extra = idle cycles expected before the start edge.
  task automatic wait_done(input bit w32, input int extra, input bit hold,
                           input int inj_cyc, input logic [31:0] inj_a, input string tag);
    exp_t        e;
    int          cyc   = 0;
    int          nbusy = 0;
    bit          seen  = 1'b0;
    logic [31:0] obs_res;
    logic        obs_err;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!hold) begin
        start8  = 1'b0;
        start32 = 1'b0;
      end
      if (cyc == inj_cyc) begin
        if (w32) begin start32 = 1'b1; a32 = inj_a; end
        else begin start8 = 1'b1; a8 = inj_a[7:0]; end
      end
      if (w32 ? busy32 : busy8) nbusy++;
      seen = w32 ? done32 : done8;
    end
    obs_res = w32 ? res32 : {24'd0, res8};
    obs_err = w32 ? err32 : err8;
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    if ((w32 ? sb32.size() : sb8.size()) == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s scoreboard: observed empty queue expected entry", tag);
    end else begin
      e = w32 ? sb32.pop_front() : sb8.pop_front();
      chk({tag, " result"}, obs_res, e.res);
      chk({tag, " error"}, 32'(obs_err), 32'(e.err));
      chk({tag, " latency"}, 32'(cyc), 32'(e.lat + extra));
      chk({tag, " busy_cycles"}, 32'(nbusy), 32'(e.lat));
      $display("done %s result=%0h error=%0b cycles=%0d", tag, obs_res, obs_err, cyc);
    end
  endtask

  task automatic quiet(input bit w32, input int n, input string tag);
    int pulses = 0;
    repeat (n) begin
      @(negedge clk);
      start8  = 1'b0;
      start32 = 1'b0;
      if (w32 ? done32 : done8) pulses++;
    end
    chk({tag, " extra_done"}, 32'(pulses), 32'd0);
    $display("quiet %s pulses=%0d", tag, pulses);
  endtask

  initial begin
    rst8_n  = 1'b0;
    rst32_n = 1'b0;
    start8  = 1'b0;
    start32 = 1'b0;
    a8      = '0;
    a32     = '0;
    repeat (3) @(negedge clk);
    chk("rst8 busy", 32'(busy8), 32'd0);
    chk("rst8 done", 32'(done8), 32'd0);
    chk("rst8 result", {24'd0, res8}, 32'd0);
    chk("rst8 error", 32'(err8), 32'd0);
    chk("rst32 busy", 32'(busy32), 32'd0);
    chk("rst32 done", 32'(done32), 32'd0);
    chk("rst32 result", res32, 32'd0);
    chk("rst32 error", 32'(err32), 32'd0);
    rst8_n  = 1'b1;
    rst32_n = 1'b1;

    launch(1'b0, 32'h05, 1'b1); wait_done(1'b0, 0, 1'b0, 0, 32'h0, "pos05");
    launch(1'b0, 32'hFB, 1'b1); wait_done(1'b0, 0, 1'b0, 0, 32'h0, "negFB");
    launch(1'b0, 32'h80, 1'b1); wait_done(1'b0, 0, 1'b0, 0, 32'h0, "min80");
    launch(1'b0, 32'h00, 1'b1); wait_done(1'b0, 0, 1'b0, 0, 32'h0, "zero");
    launch(1'b0, 32'h7F, 1'b1); wait_done(1'b0, 0, 1'b0, 0, 32'h0, "max7F");
    launch(1'b0, 32'hC0, 1'b1); wait_done(1'b0, 0, 1'b0, 0, 32'h0, "negC0");

    // Held start: second operand latched on the first IDLE edge after o_done.
    launch(1'b0, 32'hFF, 1'b1); wait_done(1'b0, 0, 1'b1, 0, 32'h0, "heldFF");
    a8 = 8'h81;
    sb8.push_back(model(8, 32'h81));
    wait_done(1'b0, 1, 1'b1, 0, 32'h0, "held81");
    @(negedge clk);
    start8 = 1'b0;
    quiet(1'b0, 3, "held_release");

    // Start during a conversion must be ignored, not queued.
    launch(1'b0, 32'hFB, 1'b1); wait_done(1'b0, 0, 1'b0, 3, 32'h05, "ignFB");
    quiet(1'b0, 12, "ign_noqueue");

    launch(1'b1, 32'h1234_5678, 1'b1); wait_done(1'b1, 0, 1'b0, 0, 32'h0, "pos32");
    launch(1'b1, 32'hFFFF_FFFF, 1'b1); wait_done(1'b1, 0, 1'b0, 0, 32'h0, "negFF32");
    launch(1'b1, 32'h8000_0000, 1'b1); wait_done(1'b1, 0, 1'b0, 0, 32'h0, "min32");
    launch(1'b1, 32'h0000_1234, 1'b1); wait_done(1'b1, 0, 1'b0, 0, 32'h0, "pos32b");

    // Asynchronous abort mid-conversion.
    launch(1'b1, 32'hFFFF_FFFE, 1'b0);
    begin
      int pulses = 0;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        start32 = 1'b0;
        if (done32) pulses++;
      end
      chk("abort early_done", 32'(pulses), 32'd0);
      rst32_n = 1'b0;
      #1;
      chk("abort result", res32, 32'd0);
      chk("abort error", 32'(err32), 32'd0);
      chk("abort busy", 32'(busy32), 32'd0);
      chk("abort done", 32'(done32), 32'd0);
      $display("abort result=%0h busy=%0b", res32, busy32);
    end
    quiet(1'b1, 3, "abort_in_reset");
    rst32_n = 1'b1;
    quiet(1'b1, 40, "abort_after");
    launch(1'b1, 32'h0000_0007, 1'b1); wait_done(1'b1, 0, 1'b0, 0, 32'h0, "post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
